// File: rtl/pipeline_stall_sequencer.sv
// ============================================================================
// pipeline_stall_sequencer: stall/flush/freeze arbiter and mult/div sequencer.
// Rev 1.0
// ============================================================================
`default_nettype none

module pipeline_stall_sequencer #(
  parameter int MULDIV_CYCLES = 32,
  parameter int STALL_CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ID_EX_MemRead,
  input  logic [4:0]             ID_EX_Rt,
  input  logic [4:0]             IF_ID_Rs,
  input  logic [4:0]             IF_ID_Rt,
  input  logic                   ID_EX_Jump,
  input  logic                   EX_Branch_Taken,
  input  logic                   IF_ID_UsesHiLo,
  input  logic                   EX_MulDiv_Start,
  input  logic                   EX_MEM_MemAccess,
  input  logic                   Dmem_Ready,
  output logic                   PC_Hold,
  output logic                   IF_ID_Hold,
  output logic                   IF_ID_Flush,
  output logic                   ID_EX_Hold,
  output logic                   ID_EX_Bubble,
  output logic                   EX_MEM_Hold,
  output logic                   MEM_WB_Bubble,
  output logic                   MulDiv_Load,
  output logic                   MulDiv_Step,
  output logic                   MulDiv_Done,
  output logic                   MulDiv_Busy,
  output logic [STALL_CNT_W-1:0] Stall_Count
);

  localparam int CNT_W = 6;
  localparam logic [1:0]             c_IDLE     = 2'd0;
  localparam logic [1:0]             c_RUN      = 2'd1;
  localparam logic [1:0]             c_DONE     = 2'd2;
  localparam logic [CNT_W-1:0]       c_CNT_INIT = CNT_W'(MULDIV_CYCLES - 1);
  localparam logic [CNT_W-1:0]       c_CNT_ONE  = CNT_W'(1);
  localparam logic [STALL_CNT_W-1:0] c_STL_ONE  = STALL_CNT_W'(1);

  logic [1:0]             r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  logic w_freeze;
  logic w_load_use;
  logic w_hilo_stall;

  assign w_freeze     = EX_MEM_MemAccess & ~Dmem_Ready;
  assign w_load_use   = ID_EX_MemRead & (ID_EX_Rt != 5'd0) &
                        ((ID_EX_Rt == IF_ID_Rs) | (ID_EX_Rt == IF_ID_Rt));
  assign w_hilo_stall = IF_ID_UsesHiLo & (r_state != c_IDLE);

  // Every combinational control is held low while reset is asserted.
  always_comb begin
    PC_Hold       = 1'b0;
    IF_ID_Hold    = 1'b0;
    IF_ID_Flush   = 1'b0;
    ID_EX_Hold    = 1'b0;
    ID_EX_Bubble  = 1'b0;
    EX_MEM_Hold   = 1'b0;
    MEM_WB_Bubble = 1'b0;
    MulDiv_Load   = 1'b0;
    MulDiv_Step   = 1'b0;
    MulDiv_Done   = 1'b0;
    MulDiv_Busy   = 1'b0;
    if (rst_n) begin
      MulDiv_Busy = (r_state != c_IDLE);
      if (w_freeze) begin
        PC_Hold       = 1'b1;
        IF_ID_Hold    = 1'b1;
        ID_EX_Hold    = 1'b1;
        EX_MEM_Hold   = 1'b1;
        MEM_WB_Bubble = 1'b1;
      end else if (EX_Branch_Taken) begin
        IF_ID_Flush  = 1'b1;
        ID_EX_Bubble = 1'b1;
      end else if (w_hilo_stall || w_load_use) begin
        PC_Hold      = 1'b1;
        IF_ID_Hold   = 1'b1;
        ID_EX_Bubble = 1'b1;
      end else if (ID_EX_Jump) begin
        IF_ID_Flush = 1'b1;
      end
      case (r_state)
        c_IDLE:  MulDiv_Load = EX_MulDiv_Start & ~w_freeze;
        c_RUN:   MulDiv_Step = 1'b1;
        c_DONE:  MulDiv_Done = 1'b1;
        default: ;
      endcase
    end
  end

  // The step in which r_cnt reads zero is the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (MulDiv_Load) begin
            r_cnt   <= c_CNT_INIT;
            r_state <= c_RUN;
          end
        end
        c_RUN: begin
          if (r_cnt == '0) r_state <= c_DONE;
          else             r_cnt   <= r_cnt - c_CNT_ONE;
        end
        c_DONE:  r_state <= c_IDLE;
        default: r_state <= c_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (PC_Hold && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + c_STL_ONE;
    end
  end

  assign Stall_Count = r_stall_cnt;

endmodule

`default_nettype wire
